// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad matrix emulator and for the keypad and
// decider benches.
//   - state_e      : emulator sequencer states
//   - KEY_*        : key codes (0-9 digits, KEY_HASH = 10, KEY_STAR = 11)
//   - KEY_ROW_LUT  : code -> matrix row (index = key code)
//   - KEY_COL_LUT  : code -> matrix column (index = key code)
//   - key_legal / key_onehot : helpers for command decode
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBounce = 2'd1,
        StPress  = 2'd2,
        StGap    = 2'd3
    } state_e;

    localparam int unsigned KEY_COUNT = 12;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;

    // Entries listed from code 11 ('*') down to code 0.
    localparam logic [KEY_COUNT-1:0][1:0] KEY_ROW_LUT = {
        2'd3, 2'd3,             // '*', '#'
        2'd2, 2'd2, 2'd2,       // 9, 8, 7
        2'd1, 2'd1, 2'd1,       // 6, 5, 4
        2'd0, 2'd0, 2'd0,       // 3, 2, 1
        2'd3                    // 0
    };

    localparam logic [KEY_COUNT-1:0][1:0] KEY_COL_LUT = {
        2'd0, 2'd2,             // '*', '#'
        2'd2, 2'd1, 2'd0,       // 9, 8, 7
        2'd2, 2'd1, 2'd0,       // 6, 5, 4
        2'd2, 2'd1, 2'd0,       // 3, 2, 1
        2'd1                    // 0
    };

    function automatic logic key_legal(input logic [3:0] code);
        return code <= KEY_STAR;
    endfunction

    function automatic logic [KEY_COUNT-1:0] key_onehot(input logic [3:0] code);
        return key_legal(code) ? (KEY_COUNT'(1) << code) : '0;
    endfunction

endpackage

// File: rtl/keypad_key_map.sv
// ----------------------------------------------------------------------------
// keypad_key_map
// Passive key matrix: each closed key shorts its column strobe onto its row.
// Purely combinational, no Col -> Row register.
// Ports:
//   i_key_active [11:0] : one-hot (or zero) closed-key vector, index = key code
//   i_col        [2:0]  : column strobes from the scanner, active-high
//   o_row        [3:0]  : row returns, active-high
// ----------------------------------------------------------------------------
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic [KEY_COUNT-1:0] i_key_active,
    input  logic [2:0]           i_col,
    output logic [3:0]           o_row
);

    always_comb begin
        o_row = '0;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (i_key_active[k] && i_col[KEY_COL_LUT[k]]) begin
                o_row[KEY_ROW_LUT[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// ----------------------------------------------------------------------------
// keypad_matrix_emulator
// Responder side of the keypad column-scan protocol. Accepts key commands over
// a valid/ready handshake and replays them as a timed press / hold / release
// sequence on the Row lines, following whatever Col strobes the scanner drives.
//
// Optional build macro: KEYPAD_BOUNCE_EN
//   defined   : a legal command first spends BOUNCE_CYCLES cycles in a bounce
//               phase (key toggles closed/open each cycle, starting closed)
//               before the full hold time.
//   undefined : no bounce phase is built.
//
// Ports:
//   clock      in   1       system clock, rising edge
//   reset      in   1       asynchronous active-low reset
//   cmd_valid  in   1       key command present
//   cmd_ready  out  1       high only in IDLE
//   cmd_code   in   4       0-9 digits, 10 '#', 11 '*', 12-15 illegal
//   cmd_hold   in   HOLD_W  press length in cycles, 0 treated as 1
//   Col        in   3       column strobes, active-high
//   Row        out  4       row returns, active-high (combinational from Col)
//   key_active out  12      one-hot closed key, 0 when released
//   busy       out  1       high from acceptance until back in IDLE
//   err        out  1       1-cycle pulse after accepting an illegal code
// ----------------------------------------------------------------------------
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_W        = 8,
    parameter int unsigned GAP_CYCLES    = 6,
    parameter int unsigned BOUNCE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_code,
    input  logic [HOLD_W-1:0]    cmd_hold,
    input  logic [2:0]           Col,
    output logic [3:0]           Row,
    output logic [KEY_COUNT-1:0] key_active,
    output logic                 busy,
    output logic                 err
);

    // GAP and BOUNCE never overlap, so one phase counter serves both; it is
    // sized for the longer of the two.
    localparam int unsigned PhaseMax = (GAP_CYCLES > BOUNCE_CYCLES) ? GAP_CYCLES
                                                                    : BOUNCE_CYCLES;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);

    state_e                 r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [PhaseW-1:0]      r_phase_cnt;
    logic [KEY_COUNT-1:0]   r_key_active;
    logic                   r_cmd_ready;
    logic                   r_busy;
    logic                   r_err;
`ifdef KEYPAD_BOUNCE_EN
    logic [KEY_COUNT-1:0]   r_key_sel;
`endif

    logic                   w_transfer;
    logic                   w_legal;
    logic [HOLD_W-1:0]      w_hold_eff;
    logic [KEY_COUNT-1:0]   w_key_onehot;

    assign w_transfer   = cmd_valid && r_cmd_ready;
    assign w_legal      = key_legal(cmd_code);
    assign w_hold_eff   = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
    assign w_key_onehot = key_onehot(cmd_code);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_hold_cnt   <= '0;
            r_phase_cnt  <= '0;
            r_key_active <= '0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            r_key_sel    <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_transfer) begin
                        if (w_legal) begin
                            r_hold_cnt   <= w_hold_eff;
                            r_key_active <= w_key_onehot;
                            r_cmd_ready  <= 1'b0;
                            r_busy       <= 1'b1;
`ifdef KEYPAD_BOUNCE_EN
                            r_key_sel    <= w_key_onehot;
                            r_phase_cnt  <= PhaseW'(BOUNCE_CYCLES);
                            r_state      <= StBounce;
`else
                            r_state      <= StPress;
`endif
                        end else begin
                            // Illegal code: flag it, stay ready.
                            r_err <= 1'b1;
                        end
                    end
                end
`ifdef KEYPAD_BOUNCE_EN
                StBounce: begin
                    if (r_phase_cnt == PhaseW'(1)) begin
                        // Hold count was loaded at acceptance and is untouched here.
                        r_key_active <= r_key_sel;
                        r_state      <= StPress;
                    end else begin
                        r_phase_cnt  <= r_phase_cnt - PhaseW'(1);
                        r_key_active <= (r_key_active == '0) ? r_key_sel : '0;
                    end
                end
`endif
                StPress: begin
                    // Counts down to 1, so a full-scale hold never wraps.
                    if (r_hold_cnt == HOLD_W'(1)) begin
                        r_key_active <= '0;
                        r_phase_cnt  <= PhaseW'(GAP_CYCLES);
                        r_state      <= StGap;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                StGap: begin
                    if (r_phase_cnt == PhaseW'(1)) begin
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - PhaseW'(1);
                    end
                end
                default: begin
                    r_key_active <= '0;
                    r_cmd_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign err        = r_err;
    assign key_active = r_key_active;

    keypad_key_map u_key_map (
        .i_key_active (r_key_active),
        .i_col        (Col),
        .o_row        (Row)
    );

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// ----------------------------------------------------------------------------
// tb_keypad_matrix_emulator
// Self-checking bench for keypad_matrix_emulator. A timeline model predicts,
// for every cycle, which key is closed, the resulting Row value, cmd_ready,
// busy and err; directed scenarios are followed by randomized command streams.
// ----------------------------------------------------------------------------
module tb_keypad_matrix_emulator;

    localparam int G = 6;
`ifdef KEYPAD_BOUNCE_EN
    localparam int B = 4;
`else
    localparam int B = 0;
`endif

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_code  = 4'd0;
    logic [7:0]  cmd_hold  = 8'd0;
    logic [2:0]  Col       = 3'd0;
    logic        cmd_ready;
    logic [3:0]  Row;
    logic [11:0] key_active;
    logic        busy;
    logic        err;

    keypad_matrix_emulator #(
        .HOLD_W        (8),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_hold   (cmd_hold),
        .Col        (Col),
        .Row        (Row),
        .key_active (key_active),
        .busy       (busy),
        .err        (err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // edges seen; "cycle n" is the interval after edge n
    int col_mode = 0;   // 0 fixed, 1 rotate 001/010/100, 2 random

    // Timeline model: one command occupies a bounce window, a press window and
    // a gap; the emulator is ready again once the gap has elapsed.
    int m_free, m_blo, m_lo, m_hi, m_key, m_err;
    bit m_acc;

    function automatic int key_row(int k);
        if (k >= 1 && k <= 9) return (k - 1) / 3;
        return 3;
    endfunction

    function automatic int key_col(int k);
        if (k >= 1 && k <= 9) return (k - 1) % 3;
        if (k == 11) return 0;
        if (k == 0) return 1;
        return 2;
    endfunction

    function automatic int model_closed(int c);
        if (c >= m_blo && c < m_blo + B) return ((c - m_blo) % 2 == 0) ? m_key : -1;
        if (c >= m_lo && c <= m_hi) return m_key;
        return -1;
    endfunction

    task automatic model_reset();
        m_free = 0;
        m_blo  = -1000;
        m_lo   = 1;
        m_hi   = 0;
        m_key  = 0;
        m_err  = -1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        int k;
        logic [3:0]  exp_row;
        logic [11:0] exp_ka;
        k       = model_closed(cyc);
        exp_row = 4'd0;
        exp_ka  = 12'd0;
        if (k >= 0) begin
            exp_ka[k] = 1'b1;
            if (Col[key_col(k)]) exp_row[key_row(k)] = 1'b1;
        end
        check("key_active", {20'd0, key_active}, {20'd0, exp_ka});
        check("row", {28'd0, Row}, {28'd0, exp_row});
        check("cmd_ready", {31'd0, cmd_ready}, (cyc >= m_free) ? 32'd1 : 32'd0);
        check("busy", {31'd0, busy}, (cyc >= m_free) ? 32'd0 : 32'd1);
        check("err", {31'd0, err}, (cyc == m_err) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        bit rdy;
        int h;
        rdy = (cyc >= m_free);
        @(posedge clock);
        cyc++;
        m_acc = 1'b0;
        if (reset && rdy && cmd_valid) begin
            m_acc = 1'b1;
            if (cmd_code < 4'd12) begin
                h      = (cmd_hold == 8'd0) ? 1 : int'(cmd_hold);
                m_key  = int'(cmd_code);
                m_blo  = cyc;
                m_lo   = cyc + B;
                m_hi   = cyc + B + h - 1;
                m_free = cyc + B + h + G;
            end else begin
                m_err = cyc;
            end
        end
        #1;
        check_all();
        case (col_mode)
            1: Col = (Col == 3'b001 || Col == 3'b010 || Col == 3'b100) ?
                     {Col[1:0], Col[2]} : 3'b001;
            2: Col = 3'($urandom_range(0, 7));
            default: ;
        endcase
    endtask

    // Present a command and hold it until it transfers; waited = edges taken.
    task automatic send(input int code, input int hold, output int waited);
        cmd_valid = 1'b1;
        cmd_code  = 4'(code);
        cmd_hold  = 8'(hold);
        waited    = 0;
        do begin
            tick();
            waited++;
        end while (!m_acc && waited < 600);
        check("accept_timeout", {31'd0, m_acc}, 32'd1);
        cmd_valid = 1'b0;
    endtask

    // Run until the DUT is ready again; count cycles with a closed key.
    task automatic wait_idle(output int act, output int span);
        act  = (key_active != 12'd0) ? 1 : 0;
        span = 0;
        while (cmd_ready !== 1'b1 && span < 600) begin
            tick();
            span++;
            if (key_active != 12'd0) act++;
        end
        check("idle_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, act, span, code, hold;
        model_reset();

        // Reset low from t0 with a command already pending.
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_code  = 4'd5;
        cmd_hold  = 8'd3;
        Col       = 3'b010;
        #1;
        check_all();
        tick();
        tick();
        reset = 1'b1;

        // Held cmd_valid is taken on the first edge after reset release.
        send(5, 3, w);
        check("reset_release_accept", w, 1);
        wait_idle(act, span);
        check("code5_press_cycles", act, 3 + (B + 1) / 2);
        check("code5_ready_span", span, 3 + G + B);

        // All codes, Col rotating so each key sees matching and non-matching strobes.
        col_mode = 1;
        for (int k = 0; k < 12; k++) begin
            send(k, 4, w);
            wait_idle(act, span);
        end

        // Illegal code then an immediately accepted legal one.
        col_mode = 0;
        Col      = 3'b111;
        send(12, 5, w);
        send(7, 2, w);
        check("legal_after_illegal", w, 1);
        wait_idle(act, span);

        // Hold extremes.
        send(2, 0, w);
        wait_idle(act, span);
        check("hold0_press_cycles", act, 1 + (B + 1) / 2);
        send(9, 255, w);
        wait_idle(act, span);
        check("hold255_press_cycles", act, 255 + (B + 1) / 2);
        check("hold255_ready_span", span, 255 + G + B);

        // Asynchronous reset in the middle of a press.
        send(8, 10, w);
        tick();
        tick();
        check("mid_press_row_before", {28'd0, Row}, 32'h4);
        #2;
        reset = 1'b0;
        #1;
        check("mid_press_row_async", {28'd0, Row}, 32'd0);
        check("mid_press_key_async", {20'd0, key_active}, 32'd0);
        model_reset();
        check_all();
        tick();
        tick();
        reset = 1'b1;
        tick();
        send(3, 1, w);
        check("accept_after_reset", w, 1);
        wait_idle(act, span);

        // Randomized stream, back-to-back commands stall while busy.
        col_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) code = $urandom_range(12, 15);
            else code = $urandom_range(0, 11);
            case ($urandom_range(0, 3))
                0: hold = 0;
                1: hold = 1;
                default: hold = $urandom_range(2, 20);
            endcase
            send(code, hold, w);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(act, span);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
